mem_port_arbiter: RTL

//  Shares one single-port unified memory between the pipelined core's fetch port (IF, read-only)
//  and its load/store port (MEM). One transaction is in flight at a time.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_starve_ctr.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// grant port ids and default widths.
package mem_arb_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 32;
    localparam int unsigned DATA_WIDTH_DEF  = 32;
    localparam int unsigned MAX_D_BURST_DEF = 4;

    // Port ids used when latching the granted request payload
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ_I = 3'd1,
        REQ_D = 3'd2,
        RSP_I = 3'd3,
        RSP_D = 3'd4
    } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive data grants made while a fetch waits.
// Ports:
//   clk, reset_n  clock / async active-low reset
//   i_inc         count one data grant (saturates at MAX)
//   i_clr         clear to 0 (wins over i_inc)
//   o_sat         registered flag: count == MAX
module arb_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam int unsigned CW = $clog2(MAX + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_sat;

    // Next count: clear dominates, increment stops at MAX
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc && (r_cnt != CW'(MAX))) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_sat <= (w_cnt_nxt == CW'(MAX));
        end
    end

    assign o_sat = r_sat;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between the core's fetch port (read-only)
// and its load/store port. One transaction in flight; data has priority,
// a starvation counter forces a fetch grant after MAX_D_BURST data grants.
// Ports:
//   clk, reset_n                      clock / async active-low reset
//   if_req/if_addr/if_flush           fetch request, branch flush
//   if_ready/if_rvalid/if_rdata       fetch accept and response
//   d_req/d_we/d_addr/d_wdata/d_be    data request
//   d_ready/d_rvalid/d_rdata          data accept and response
//   m_req/m_we/m_addr/m_wdata/m_be    memory request (held until m_ready)
//   m_ready/m_rvalid/m_rdata          memory accept and response
//   arb_busy                          state != IDLE
//   perf_if_wait/perf_d_wait/perf_grants  only with MEM_ARB_PERF_EN defined
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned MAX_D_BURST = MAX_D_BURST_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_flush,
    output logic                    if_ready,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_ready,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    m_req,
    output logic                    m_we,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_be,
    input  logic                    m_ready,
    input  logic                    m_rvalid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    output logic                    arb_busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]             perf_if_wait,
    output logic [31:0]             perf_d_wait,
    output logic [31:0]             perf_grants
`endif
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;

    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_be;
    logic                    r_drop;

    logic w_arb_slot;
    logic w_gnt_d;
    logic w_gnt_i;
    logic w_grant;
    logic w_gnt_port;
    logic w_starve_sat;
    logic w_in_req;
    logic w_rsp_i_done;

    // Arbitration happens in IDLE or on the response of the current transaction
    assign w_arb_slot   = (r_state == IDLE) ||
                          (((r_state == RSP_I) || (r_state == RSP_D)) && m_rvalid);
    assign w_gnt_d      = d_req && !(if_req && w_starve_sat);
    assign w_gnt_i      = if_req && !w_gnt_d;
    assign w_grant      = w_arb_slot && (w_gnt_d || w_gnt_i);
    assign w_gnt_port   = w_gnt_d ? GRANT_D : GRANT_I;
    assign w_in_req     = (r_state == REQ_I) || (r_state == REQ_D);
    assign w_rsp_i_done = (r_state == RSP_I) && m_rvalid;

    arb_starve_ctr #(
        .MAX (MAX_D_BURST)
    ) u_starve_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_grant && w_gnt_d && if_req),
        .i_clr   (w_grant && (w_gnt_i || !if_req)),
        .o_sat   (w_starve_sat)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: response cycles re-arbitrate directly, no IDLE bubble
    always_comb begin
        w_state_nxt = r_state;
        if (w_arb_slot) begin
            if (w_gnt_d) begin
                w_state_nxt = REQ_D;
            end else if (w_gnt_i) begin
                w_state_nxt = REQ_I;
            end else begin
                w_state_nxt = IDLE;
            end
        end else begin
            case (r_state)
                REQ_I:   if (m_ready) w_state_nxt = RSP_I;
                REQ_D:   if (m_ready) w_state_nxt = RSP_D;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Payload captured at grant so m_* stay stable even if the requester misbehaves
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_grant) begin
            if (w_gnt_port == GRANT_D) begin
                r_we    <= d_we;
                r_addr  <= d_addr;
                r_wdata <= d_we ? d_wdata : '0;
                r_be    <= d_we ? d_be : '0;
            end else begin
                r_we    <= 1'b0;
                r_addr  <= if_addr;
                r_wdata <= '0;
                r_be    <= '0;
            end
        end
    end

    // Drop flag: a flushed fetch still completes in memory but its data is discarded
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop <= 1'b0;
        end else if (w_rsp_i_done) begin
            r_drop <= 1'b0;
        end else if (if_flush && ((r_state == REQ_I) || (r_state == RSP_I))) begin
            r_drop <= 1'b1;
        end
    end

    assign m_req     = w_in_req;
    assign m_we      = w_in_req && r_we;
    assign m_addr    = w_in_req ? r_addr : '0;
    assign m_wdata   = w_in_req ? r_wdata : '0;
    assign m_be      = w_in_req ? r_be : '0;

    assign if_ready  = (r_state == REQ_I) && m_ready;
    assign d_ready   = (r_state == REQ_D) && m_ready;

    // A flush arriving with the response also discards it
    assign if_rvalid = w_rsp_i_done && !r_drop && !if_flush;
    assign if_rdata  = if_rvalid ? m_rdata : '0;
    assign d_rvalid  = (r_state == RSP_D) && m_rvalid;
    assign d_rdata   = (d_rvalid && !r_we) ? m_rdata : '0;

    assign arb_busy  = (r_state != IDLE);

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_if_wait;
    logic [31:0] r_perf_d_wait;
    logic [31:0] r_perf_grants;

    // Free-running wait/grant counters, wrap naturally at 2^32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_if_wait <= '0;
            r_perf_d_wait  <= '0;
            r_perf_grants  <= '0;
        end else begin
            if (if_req && !if_ready) r_perf_if_wait <= r_perf_if_wait + 32'd1;
            if (d_req && !d_ready)   r_perf_d_wait  <= r_perf_d_wait + 32'd1;
            if (m_req && m_ready)    r_perf_grants  <= r_perf_grants + 32'd1;
        end
    end

    assign perf_if_wait = r_perf_if_wait;
    assign perf_d_wait  = r_perf_d_wait;
    assign perf_grants  = r_perf_grants;
`endif

    // Requesters must hold their request until accepted (a flushed fetch may withdraw)
    always @(posedge clk) begin
        if (reset_n && (r_state == REQ_D)) begin
            assert (d_req);
        end
        if (reset_n && (r_state == REQ_I) && !r_drop && !if_flush) begin
            assert (if_req);
        end
    end

endmodule
